// File: rtl/xmuladdlite_conf.sv
// xmuladdlite_conf: writer side of the muladdlite configuration port.
// Optional field readback: define MULADDLITE_CONF_READBACK_EN.

`ifndef MULADDLITE_N_W
`define MULADDLITE_N_W 5
`endif
`ifndef MULADDLITE_MEM_ADDR_W
`define MULADDLITE_MEM_ADDR_W 10
`endif
`ifndef MULADDLITE_PERIOD_W
`define MULADDLITE_PERIOD_W 5
`endif
`ifndef MULADDLITE_SHIFT_W
`define MULADDLITE_SHIFT_W 6
`endif
`ifndef MULADDLITE_CONF_BITS
`define MULADDLITE_CONF_BITS (3*`MULADDLITE_N_W + `MULADDLITE_MEM_ADDR_W + 2*`MULADDLITE_PERIOD_W + `MULADDLITE_SHIFT_W + 3)
`endif

module xmuladdlite_conf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    input  logic                             req_we,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic [DATA_W-1:0]                req_wdata,
    output logic                             req_ready,
    input  logic                             fu_run,
    output logic [`MULADDLITE_CONF_BITS-1:0] configdata,
    output logic                             conf_upd,
    output logic                             busy
`ifdef MULADDLITE_CONF_READBACK_EN
    ,
    output logic [DATA_W-1:0]                rdata,
    output logic                             rvalid
`endif
);

    localparam int N_W    = `MULADDLITE_N_W;
    localparam int MEM_W  = `MULADDLITE_MEM_ADDR_W;
    localparam int PER_W  = `MULADDLITE_PERIOD_W;
    localparam int SHF_W  = `MULADDLITE_SHIFT_W;
    localparam int CONF_W = `MULADDLITE_CONF_BITS;

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(8);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [N_W-1:0]   r_sela;
    logic [N_W-1:0]   r_selb;
    logic [N_W-1:0]   r_selc;
    logic [MEM_W-1:0] r_iter;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_delay;
    logic [SHF_W-1:0] r_shift;
    logic             r_acc_in;
    logic             r_acc_out;
    logic             r_batch;

    logic [CONF_W-1:0] r_cfg;
    logic              r_upd;

    logic              w_acc;
    logic              w_is_fld;
    logic              w_is_ctrl;
    logic              w_commit;
    logic              w_clear;
    logic              w_fld_we;
    logic [CONF_W-1:0] w_shadow;
    logic [CONF_W-1:0] w_cfg_nxt;
    logic              w_unused_wdata;

    // Only the low bits of write data reach any field.
    assign w_unused_wdata = ^req_wdata;

`ifdef MULADDLITE_CONF_READBACK_EN
    // Reads never touch the shadow set, so they may bypass the commit stall.
    assign req_ready = (r_state == ST_IDLE) | (req_valid & ~req_we);
`else
    assign req_ready = (r_state == ST_IDLE);
`endif

    assign w_acc      = req_valid & req_ready;
    assign w_is_fld   = (req_addr < A_CTRL);
    assign w_is_ctrl  = (req_addr == A_CTRL);
    assign busy       = (r_state == ST_WAIT);
    assign configdata = r_cfg;
    assign conf_upd   = r_upd;

    assign w_shadow = {r_sela, r_selb, r_selc, r_iter, r_period,
                       r_delay, r_shift, r_acc_in, r_acc_out, r_batch};

    // A clear in the same ctrl word as an update commits the cleared set.
    assign w_cfg_nxt = w_clear ? '0 : w_shadow;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus request decode: field write, clear, commit.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_clear     = 1'b0;
        w_fld_we    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc && req_we) begin
                    unique case (1'b1)
                        w_is_fld: begin
                            w_fld_we = 1'b1;
                        end
                        w_is_ctrl: begin
                            w_clear = req_wdata[1];
                            if (req_wdata[0]) begin
                                if (fu_run) begin
                                    w_state_nxt = ST_WAIT;
                                end else begin
                                    w_commit = 1'b1;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                if (!fu_run) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shadow field registers, written one field per accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sela    <= '0;
            r_selb    <= '0;
            r_selc    <= '0;
            r_iter    <= '0;
            r_period  <= '0;
            r_delay   <= '0;
            r_shift   <= '0;
            r_acc_in  <= 1'b0;
            r_acc_out <= 1'b0;
            r_batch   <= 1'b0;
        end else if (w_clear) begin
            r_sela    <= '0;
            r_selb    <= '0;
            r_selc    <= '0;
            r_iter    <= '0;
            r_period  <= '0;
            r_delay   <= '0;
            r_shift   <= '0;
            r_acc_in  <= 1'b0;
            r_acc_out <= 1'b0;
            r_batch   <= 1'b0;
        end else if (w_fld_we) begin
            case (req_addr[2:0])
                3'd0: r_sela   <= req_wdata[N_W-1:0];
                3'd1: r_selb   <= req_wdata[N_W-1:0];
                3'd2: r_selc   <= req_wdata[N_W-1:0];
                3'd3: r_iter   <= req_wdata[MEM_W-1:0];
                3'd4: r_period <= req_wdata[PER_W-1:0];
                3'd5: r_delay  <= req_wdata[PER_W-1:0];
                3'd6: r_shift  <= req_wdata[SHF_W-1:0];
                default: begin
                    r_acc_in  <= req_wdata[0];
                    r_acc_out <= req_wdata[1];
                    r_batch   <= req_wdata[2];
                end
            endcase
        end
    end

    // Active configuration: reloaded only on a commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= '0;
            r_upd <= 1'b0;
        end else begin
            r_upd <= w_commit;
            if (w_commit) begin
                r_cfg <= w_cfg_nxt;
            end
        end
    end

`ifdef MULADDLITE_CONF_READBACK_EN
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic [DATA_W-1:0] w_rd_data;

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

    // Readback mux: shadow fields zero-extended, status at the ctrl address.
    always_comb begin
        w_rd_data = '0;
        if (w_is_fld) begin
            case (req_addr[2:0])
                3'd0: w_rd_data[N_W-1:0]   = r_sela;
                3'd1: w_rd_data[N_W-1:0]   = r_selb;
                3'd2: w_rd_data[N_W-1:0]   = r_selc;
                3'd3: w_rd_data[MEM_W-1:0] = r_iter;
                3'd4: w_rd_data[PER_W-1:0] = r_period;
                3'd5: w_rd_data[PER_W-1:0] = r_delay;
                3'd6: w_rd_data[SHF_W-1:0] = r_shift;
                default: w_rd_data[2:0] = {r_batch, r_acc_out, r_acc_in};
            endcase
        end else if (w_is_ctrl) begin
            w_rd_data[1:0] = {busy, r_state == ST_WAIT};
        end
    end

    // Read response, valid for the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_acc & ~req_we;
            if (w_acc && !req_we) begin
                r_rdata <= w_rd_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xmuladdlite_conf.sv
// tb_xmuladdlite_conf: randomized and directed checks of xmuladdlite_conf
// against a field-level model of the shadow set and active config.

`ifndef MULADDLITE_N_W
`define MULADDLITE_N_W 5
`endif
`ifndef MULADDLITE_MEM_ADDR_W
`define MULADDLITE_MEM_ADDR_W 10
`endif
`ifndef MULADDLITE_PERIOD_W
`define MULADDLITE_PERIOD_W 5
`endif
`ifndef MULADDLITE_SHIFT_W
`define MULADDLITE_SHIFT_W 6
`endif

module tb_xmuladdlite_conf;

    localparam int NW = `MULADDLITE_N_W;
    localparam int MW = `MULADDLITE_MEM_ADDR_W;
    localparam int PW = `MULADDLITE_PERIOD_W;
    localparam int SW = `MULADDLITE_SHIFT_W;
    localparam int CB = 3*NW + MW + 2*PW + SW + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_valid;
    logic          req_we;
    logic [3:0]    req_addr;
    logic [31:0]   req_wdata;
    logic          fu_run;
    wire           req_ready;
    wire           conf_upd;
    wire           busy;
    wire  [CB-1:0] configdata;
`ifdef MULADDLITE_CONF_READBACK_EN
    wire  [31:0]   rdata;
    wire           rvalid;
`endif

    xmuladdlite_conf #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .fu_run     (fu_run),
        .configdata (configdata),
        .conf_upd   (conf_upd),
        .busy       (busy)
`ifdef MULADDLITE_CONF_READBACK_EN
        ,
        .rdata      (rdata),
        .rvalid     (rvalid)
`endif
    );

    int total = 0;
    int bad   = 0;

    int unsigned   m_sh [8];
    logic [CB-1:0] m_cfg;
    bit            m_wait;
    bit            m_upd;
    logic [31:0]   m_rd;

    function automatic int unsigned fw(int a);
        case (a)
            0, 1, 2: return NW;
            3:       return MW;
            4, 5:    return PW;
            6:       return SW;
            default: return 3;
        endcase
    endfunction

    // Fields MSB first; flag bits land as accIN, accOUT, batch.
    function automatic logic [CB-1:0] pack();
        logic [63:0] p;
        p = 64'd0;
        for (int i = 0; i < 7; i++) p = (p << fw(i)) | 64'(m_sh[i]);
        p = (p << 1) | 64'(m_sh[7] & 1);
        p = (p << 1) | 64'((m_sh[7] >> 1) & 1);
        p = (p << 1) | 64'((m_sh[7] >> 2) & 1);
        return p[CB-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_sh[i] = 0;
        m_cfg  = '0;
        m_wait = 0;
        m_upd  = 0;
        m_rd   = '0;
    endtask

    task automatic model_apply(input logic we, input int a, input logic [31:0] d);
        m_upd = 0;
        if (!we) begin
            if (a < 8) m_rd = m_sh[a];
            else if (a == 8) m_rd = {30'd0, m_wait, m_wait};
            else m_rd = '0;
        end else if (a < 8) begin
            m_sh[a] = d & ((32'd1 << fw(a)) - 1);
        end else if (a == 8) begin
            if (d[1]) for (int i = 0; i < 8; i++) m_sh[i] = 0;
            if (d[0]) begin
                if (fu_run) m_wait = 1;
                else begin
                    m_cfg = pack();
                    m_upd = 1;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic do_req(input logic we, input int a, input logic [31:0] d);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = 4'(a);
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_timeout addr=%0d ready=%b required=1", a, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_apply(we, a, d);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0;
        req_wdata = 0; fu_run = 0;
        model_reset();
        #12;
        total++;
        if (configdata !== '0 || busy !== 1'b0 || conf_upd !== 1'b0) begin
            bad++;
            $display("FAIL reset_init cfg=%h busy=%b upd=%b required 0/0/0", configdata, busy, conf_upd);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b required=1", req_ready);
        end
        do_req(1, 3, 32'd16);
        do_req(1, 8, 32'd1);
        total++;
        if (conf_upd !== 1'b1 || configdata !== m_cfg) begin
            bad++;
            $display("FAIL reset_pre_commit upd=%b cfg=%h required 1/%h", conf_upd, configdata, m_cfg);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (configdata !== '0 || conf_upd !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_upd cfg=%h upd=%b busy=%b required 0/0/0", configdata, conf_upd, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        do_req(1, 0, 32'd4);
        fu_run = 1'b1;
        do_req(1, 8, 32'd1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_wait busy=%b required=1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (busy !== 1'b0 || configdata !== '0 || conf_upd !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_wait busy=%b cfg=%h upd=%b required 0/0/0", busy, configdata, conf_upd);
        end
        fu_run = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b required=1", req_ready);
        end
        do_req(1, 8, 32'd1);
        total++;
        if (configdata !== '0 || conf_upd !== 1'b1) begin
            bad++;
            $display("FAIL reset_shadow_zero cfg=%h upd=%b required 0/1", configdata, conf_upd);
        end
    endtask

    task automatic test_commit_idle();
        logic [CB-1:0] prev;
        fu_run = 1'b0;
        do_req(1, 0, 32'd3);
        do_req(1, 3, 32'd16);
        do_req(1, 4, 32'd4);
        do_req(1, 6, 32'd8);
        do_req(1, 7, 32'b101);
        prev = m_cfg;
        total++;
        if (configdata !== prev || conf_upd !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_early_commit cfg=%h upd=%b required %h/0", configdata, conf_upd, prev);
        end
        do_req(1, 8, 32'd1);
        total++;
        if (configdata !== m_cfg || conf_upd !== 1'b1) begin
            bad++;
            $display("FAIL idle_commit cfg=%h upd=%b required %h/1", configdata, conf_upd, m_cfg);
        end
        total++;
        if (configdata[CB-1 -: 5] !== 5'd3 || configdata[2:0] !== 3'b101) begin
            bad++;
            $display("FAIL idle_fields sela=%0d flags=%b required 3/101", configdata[CB-1 -: 5], configdata[2:0]);
        end
        @(negedge clk);
        total++;
        if (conf_upd !== 1'b0) begin
            bad++;
            $display("FAIL idle_upd_width upd=%b required=0", conf_upd);
        end
    endtask

    task automatic test_commit_wait();
        logic [CB-1:0] held;
        fu_run = 1'b0;
        do_req(1, 1, 32'd7);
        fu_run = 1'b1;
        held = m_cfg;
        do_req(1, 8, 32'd1);
        total++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || configdata !== held || conf_upd !== 1'b0) begin
            bad++;
            $display("FAIL wait_enter busy=%b ready=%b cfg=%h upd=%b required 1/0/%h/0", busy, req_ready, configdata, conf_upd, held);
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_wdata = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 1'b0 || configdata !== held || busy !== 1'b1) begin
                bad++;
                $display("FAIL wait_stall cyc=%0d ready=%b cfg=%h busy=%b required 0/%h/1", i, req_ready, configdata, busy, held);
            end
        end
        fu_run = 1'b0;
        @(negedge clk);
        m_cfg = pack(); m_wait = 0;
        total++;
        if (conf_upd !== 1'b1 || busy !== 1'b0 || configdata !== m_cfg || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL wait_commit upd=%b busy=%b cfg=%h ready=%b required 1/0/%h/1", conf_upd, busy, configdata, req_ready, m_cfg);
        end
        @(posedge clk);
        model_apply(1, 0, 32'd9);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (conf_upd !== 1'b0) begin
            bad++;
            $display("FAIL wait_upd_width upd=%b required=0", conf_upd);
        end
        do_req(1, 8, 32'd1);
        total++;
        if (configdata !== m_cfg || configdata[CB-1 -: 5] !== 5'd9) begin
            bad++;
            $display("FAIL wait_stalled_write cfg=%h required %h", configdata, m_cfg);
        end
    endtask

    task automatic test_trunc_ignore();
        fu_run = 1'b0;
        do_req(1, 7, 32'hFFFF_FFFF);
        do_req(1, 12, 32'h1234_5678);
        do_req(1, 15, 32'hFFFF_FFFF);
        do_req(1, 8, 32'd1);
        total++;
        if (configdata !== m_cfg || configdata[2:0] !== 3'b111) begin
            bad++;
            $display("FAIL trunc_ignore cfg=%h required %h", configdata, m_cfg);
        end
    endtask

    task automatic test_clear_update();
        fu_run = 1'b0;
        do_req(1, 2, 32'd11);
        do_req(1, 8, 32'd3);
        total++;
        if (configdata !== '0 || conf_upd !== 1'b1 || m_cfg !== '0) begin
            bad++;
            $display("FAIL clear_update cfg=%h upd=%b required 0/1", configdata, conf_upd);
        end
    endtask

`ifdef MULADDLITE_CONF_READBACK_EN
    task automatic test_readback();
        fu_run = 1'b0;
        do_req(1, 5, 32'd5);
        do_req(0, 5, 32'd0);
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'd5) begin
            bad++;
            $display("FAIL rb_delay rvalid=%b rdata=%h required 1/5", rvalid, rdata);
        end
        fu_run = 1'b1;
        do_req(1, 8, 32'd1);
        do_req(0, 8, 32'd0);
        total++;
        if (rvalid !== 1'b1 || rdata[1:0] !== 2'b11 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rb_status rvalid=%b rdata=%h busy=%b required 1/3/1", rvalid, rdata, busy);
        end
        fu_run = 1'b0;
        @(negedge clk);
        m_cfg = pack(); m_wait = 0;
        total++;
        if (configdata !== m_cfg || conf_upd !== 1'b1) begin
            bad++;
            $display("FAIL rb_wait_commit cfg=%h upd=%b required %h/1", configdata, conf_upd, m_cfg);
        end
    endtask
`endif

    task automatic test_random();
        int a;
        int k;
        logic we;
        logic [31:0] d;
        for (int it = 0; it < 300; it++) begin
            a  = $urandom_range(0, 12);
            we = ($urandom_range(0, 4) != 0);
            d  = (a == 8) ? 32'($urandom_range(0, 3)) : $urandom;
            fu_run = ($urandom_range(0, 3) == 0);
            do_req(we, a, d);
            total++;
            if (configdata !== m_cfg || conf_upd !== m_upd || busy !== m_wait) begin
                bad++;
                $display("FAIL rand_req it=%0d cfg=%h upd=%b busy=%b required %h/%b/%b", it, configdata, conf_upd, busy, m_cfg, m_upd, m_wait);
            end
`ifdef MULADDLITE_CONF_READBACK_EN
            if (!we) begin
                total++;
                if (rvalid !== 1'b1 || rdata !== m_rd) begin
                    bad++;
                    $display("FAIL rand_read it=%0d rvalid=%b rdata=%h required 1/%h", it, rvalid, rdata, m_rd);
                end
            end
`endif
            if (m_wait) begin
                k = $urandom_range(0, 3);
                for (int c = 0; c < k; c++) @(negedge clk);
                fu_run = 1'b0;
                @(negedge clk);
                m_cfg = pack(); m_wait = 0;
                total++;
                if (configdata !== m_cfg || conf_upd !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_wait it=%0d cfg=%h upd=%b busy=%b required %h/1/0", it, configdata, conf_upd, busy, m_cfg);
                end
            end
        end
        fu_run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit_idle();
        test_commit_wait();
        test_trunc_ignore();
        test_clear_update();
`ifdef MULADDLITE_CONF_READBACK_EN
        test_readback();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
